// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared cause indices, FSM encoding and mask boundary for int_ctrl
package int_pkg;

    localparam int N_EXT_LINES = 25;

    localparam int C_RESET = 0;
    localparam int C_ILL   = 1;
    localparam int C_MAL   = 2;
    localparam int C_PFF   = 3;
    localparam int C_PFLS  = 4;
    localparam int C_SYSC  = 5;
    localparam int C_OVF   = 6;
    localparam int C_EXT0  = 7;

    // Cause bits below this index ignore sr; sr[31:MASK_LO] enables the rest.
    localparam int MASK_LO = 6;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;
    localparam logic [1:0] ST_RET  = 2'd3;

endpackage

// File: rtl/prio_enc32.sv
// rtl/prio_enc32.sv - lowest-set-bit encoder, 32-bit vector to 5-bit index plus none flag
module prio_enc32 (
    input  logic [31:0] in_i,
    output logic [4:0]  idx_o,
    output logic        none_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o = 5'(i);
            end
        end
    end

    assign none_o = ~|in_i;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt cause collector and one-cycle trap/eret sequencer in front of spr
module int_ctrl
    import int_pkg::*;
#(
    parameter int N_EXT = N_EXT_LINES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid_i,
    input  logic             ill_i,
    input  logic             mal_i,
    input  logic             pff_i,
    input  logic             pfls_i,
    input  logic             sysc_i,
    input  logic             ovf_i,
    input  logic             eret_i,
    input  logic [N_EXT-1:0] ext_ev_i,
    input  logic [31:0]      sr_i,
    output logic             jisr_o,
    output logic [31:0]      mca_o,
    output logic             rpt_o,
    output logic [4:0]       il_o,
    output logic             eret_go_o,
    output logic [N_EXT-1:0] pending_o
);

    state_t           state_q, state_d;
    logic             jisr_q, jisr_d;
    logic [31:0]      mca_q, mca_d;
    logic             rpt_q, rpt_d;
    logic [4:0]       il_q, il_d;
    logic             eret_go_q, eret_go_d;
    logic [N_EXT-1:0] pending_q, pending_d;

    logic [31:0]      ca;
    logic [31:0]      mca_c;
    logic [31:0]      clr_onehot;
    logic             clr_en;
    logic [4:0]       enc_idx;
    logic             enc_none;

    assign ca = {pending_q | ext_ev_i,
                 {ovf_i, sysc_i, pfls_i, pff_i, mal_i, ill_i} & {6{instr_valid_i}},
                 1'b0};
    assign mca_c = ca & {sr_i[31:MASK_LO], {MASK_LO{1'b1}}};

    prio_enc32 u_prio_enc32 (
        .in_i   (mca_c),
        .idx_o  (enc_idx),
        .none_o (enc_none)
    );

    assign clr_onehot = 32'h1 << enc_idx;

    always_comb begin
        state_d   = state_q;
        jisr_d    = 1'b0;
        mca_d     = 32'h0;
        rpt_d     = 1'b0;
        il_d      = 5'd0;
        eret_go_d = 1'b0;
        clr_en    = 1'b0;
        case (state_q)
            ST_RST: begin
                state_d = ST_TRAP;
                jisr_d  = 1'b1;
                mca_d   = 32'h1;
            end
            ST_RUN: begin
                // An interrupt outranks an eret on the same instruction.
                if (instr_valid_i && !enc_none) begin
                    state_d = ST_TRAP;
                    jisr_d  = 1'b1;
                    mca_d   = mca_c;
                    il_d    = enc_idx;
                    rpt_d   = (enc_idx == 5'(C_PFF)) || (enc_idx == 5'(C_PFLS));
                    clr_en  = 1'b1;
                end else if (instr_valid_i && eret_i) begin
                    state_d   = ST_RET;
                    eret_go_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Only external indices land in pending; lower one-hot bits fall off the slice.
        pending_d = (pending_q & ~(clr_en ? clr_onehot[31:C_EXT0] : '0)) | ext_ev_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RST;
            jisr_q    <= 1'b0;
            mca_q     <= 32'h0;
            rpt_q     <= 1'b0;
            il_q      <= 5'd0;
            eret_go_q <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            jisr_q    <= jisr_d;
            mca_q     <= mca_d;
            rpt_q     <= rpt_d;
            il_q      <= il_d;
            eret_go_q <= eret_go_d;
            pending_q <= pending_d;
        end
    end

    assign jisr_o    = jisr_q;
    assign mca_o     = mca_q;
    assign rpt_o     = rpt_q;
    assign il_o      = il_q;
    assign eret_go_o = eret_go_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - randomized and directed self-checking bench for int_ctrl
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic        ill_i = 1'b0, mal_i = 1'b0, pff_i = 1'b0, pfls_i = 1'b0, sysc_i = 1'b0, ovf_i = 1'b0;
    logic        eret_i = 1'b0;
    logic [24:0] ext_ev_i = '0;
    logic [31:0] sr_i = '0;
    logic        jisr_o;
    logic [31:0] mca_o;
    logic        rpt_o;
    logic [4:0]  il_o;
    logic        eret_go_o;
    logic [24:0] pending_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle.
    logic        e_jisr = 0, e_rpt = 0, e_eret = 0;
    logic [31:0] e_mca = 0;
    logic [4:0]  e_il = 0;
    logic [24:0] e_pend = 0;

    // Model state: boot trap owed, flush cycle owed, latched events.
    bit          m_boot = 1'b1;
    bit          m_flush = 1'b0;
    logic [24:0] m_pend = '0;
    logic        n_jisr, n_rpt, n_eret;
    logic [31:0] n_mca;
    logic [4:0]  n_il;

    always #5 clk = ~clk;

    int_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid_i (instr_valid_i),
        .ill_i         (ill_i),
        .mal_i         (mal_i),
        .pff_i         (pff_i),
        .pfls_i        (pfls_i),
        .sysc_i        (sysc_i),
        .ovf_i         (ovf_i),
        .eret_i        (eret_i),
        .ext_ev_i      (ext_ev_i),
        .sr_i          (sr_i),
        .jisr_o        (jisr_o),
        .mca_o         (mca_o),
        .rpt_o         (rpt_o),
        .il_o          (il_o),
        .eret_go_o     (eret_go_o),
        .pending_o     (pending_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("jisr",    32'(jisr_o),    32'(e_jisr));
            check("mca",     mca_o,          e_mca);
            check("rpt",     32'(rpt_o),     32'(e_rpt));
            check("il",      32'(il_o),      32'(e_il));
            check("eret_go", 32'(eret_go_o), 32'(e_eret));
            check("pending", 32'(pending_o), 32'(e_pend));
        end
    end

    // Predicts what one rising edge does, from the cause/mask/priority rules.
    task automatic model_step();
        logic [31:0] cause;
        logic [24:0] clr;
        int          low;
        n_jisr = 0; n_rpt = 0; n_eret = 0; n_mca = 0; n_il = 0;
        clr = '0;
        if (m_boot) begin
            n_jisr = 1; n_mca = 32'h1;
            m_boot = 0; m_flush = 1;
        end else if (m_flush) begin
            m_flush = 0;
        end else if (instr_valid_i) begin
            cause = {m_pend | ext_ev_i, ovf_i, sysc_i, pfls_i, pff_i, mal_i, ill_i, 1'b0};
            for (int i = 6; i < 32; i++) if (!sr_i[i]) cause[i] = 1'b0;
            if (cause != 0) begin
                low = 0;
                while (!cause[low]) low++;
                n_jisr = 1; n_mca = cause; n_il = 5'(low);
                n_rpt = (low == 3) || (low == 4);
                if (low >= 7) clr[low - 7] = 1'b1;
                m_flush = 1;
            end else if (eret_i) begin
                n_eret = 1; m_flush = 1;
            end
        end
        m_pend = (m_pend & ~clr) | ext_ev_i;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        e_jisr = n_jisr; e_mca = n_mca; e_rpt = n_rpt; e_il = n_il; e_eret = n_eret; e_pend = m_pend;
        #2;
    endtask

    // c = {ovf, sysc, pfls, pff, mal, ill}
    task automatic step(input bit v, input logic [5:0] c, input bit er, input logic [24:0] ev,
                        input logic [31:0] s);
        @(negedge clk);
        #1;
        instr_valid_i = v;
        {ovf_i, sysc_i, pfls_i, pff_i, mal_i, ill_i} = c;
        eret_i = er; ext_ev_i = ev; sr_i = s;
        tick();
    endtask

    task automatic idle();
        step(0, 6'b0, 0, '0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_boot = 1; m_flush = 0; m_pend = '0;
        e_jisr = 0; e_mca = 0; e_rpt = 0; e_il = 0; e_eret = 0; e_pend = 0;
        #1;
        check("rst_jisr",    32'(jisr_o),    32'h0);
        check("rst_mca",     mca_o,          32'h0);
        check("rst_eret",    32'(eret_go_o), 32'h0);
        check("rst_pending", 32'(pending_o), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        instr_valid_i = 0; {ovf_i, sysc_i, pfls_i, pff_i, mal_i, ill_i} = '0;
        eret_i = 0; ext_ev_i = '0; sr_i = '0;
        tick();
    endtask

    initial begin
        chk_en = 1'b1;
        do_reset();
        check("boot_jisr", 32'(jisr_o), 32'h1);
        check("boot_mca",  mca_o,       32'h1);
        check("boot_il",   32'(il_o),   32'h0);
        check("boot_rpt",  32'(rpt_o),  32'h0);
        idle();
        check("boot_jisr_off", 32'(jisr_o), 32'h0);
        idle();

        step(1, 6'b000101, 0, '0, 32'h0);
        check("prec_mca", mca_o, 32'h0000000A);
        check("prec_il",  32'(il_o),  32'd1);
        check("prec_rpt", 32'(rpt_o), 32'h0);
        idle();
        check("prec_one_cycle", 32'(jisr_o), 32'h0);
        idle();
        step(1, 6'b001000, 0, '0, 32'h0);
        check("pfls_mca", mca_o, 32'h10);
        check("pfls_il",  32'(il_o),  32'd4);
        check("pfls_rpt", 32'(rpt_o), 32'h1);
        idle(); idle();

        step(0, 6'b0, 0, 25'h1, 32'h0);
        step(1, 6'b0, 0, '0, 32'h0);
        check("mask_no_trap", 32'(jisr_o), 32'h0);
        check("mask_pending", 32'(pending_o), 32'h1);
        step(1, 6'b0, 0, '0, 32'h80);
        check("ext_jisr", 32'(jisr_o), 32'h1);
        check("ext_mca",  mca_o,       32'h80);
        check("ext_il",   32'(il_o),   32'd7);
        check("ext_pend_clr", 32'(pending_o), 32'h0);
        idle(); idle();

        step(1, 6'b100000, 0, '0, 32'h0);
        check("ovf_masked", 32'(jisr_o), 32'h0);
        step(1, 6'b100000, 0, '0, 32'h40);
        check("ovf_mca", mca_o, 32'h40);
        check("ovf_il",  32'(il_o), 32'd6);
        idle(); idle();

        step(1, 6'b0, 1, '0, 32'h0);
        check("eret_go",   32'(eret_go_o), 32'h1);
        check("eret_jisr", 32'(jisr_o),    32'h0);
        idle();
        check("eret_pulse", 32'(eret_go_o), 32'h0);
        idle();
        step(1, 6'b010000, 1, '0, 32'h0);
        check("sysc_jisr", 32'(jisr_o),    32'h1);
        check("sysc_mca",  mca_o,          32'h20);
        check("sysc_eret", 32'(eret_go_o), 32'h0);
        idle();
        check("sysc_eret2", 32'(eret_go_o), 32'h0);
        idle();

        step(0, 6'b0, 0, 25'h1, 32'h0);
        step(1, 6'b0, 0, 25'h1, 32'h80);
        check("setclr_il",   32'(il_o),      32'd7);
        check("setclr_pend", 32'(pending_o), 32'h1);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            logic [5:0]  c;
            logic [24:0] ev;
            for (int b = 0; b < 6; b++) c[b] = ($urandom_range(0, 7) == 0);
            ev = 25'($urandom & $urandom & $urandom & $urandom);
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, c, $urandom_range(0, 3) == 0, ev, $urandom);
            end
        end

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
